// File: rtl/mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_pkg
// Description : Shared types, default sizes and helpers for the modulation
//               sample store and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_pkg;

    localparam int C_DEF_WIDTH = 8;
    localparam int C_DEF_DEPTH = 32768;
    localparam int C_DEF_DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN_S = 2'd2
    } seq_state_t;

    // A divider value of zero behaves like one: step on every tick.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : mod_sdp_ram
// Description : Simple dual-port block RAM, read-first, one-cycle registered
//               read, no reset on the data path.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_sdp_ram #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Both accesses in one process so a same-address collision returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/modulation_sampler.sv
`default_nettype none
// ============================================================================
// Module      : modulation_sampler
// Description : Double-segmented modulation store; steps through the active
//               segment on divided sync ticks and swaps segments only at wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module modulation_sampler
    import mod_pkg::*;
#(
    parameter  int WIDTH  = C_DEF_WIDTH,
    parameter  int DEPTH  = C_DEF_DEPTH,
    parameter  int DIV_W  = C_DEF_DIV_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              sync_tick,
    input  logic [DIV_W-1:0]  freq_div,
    input  logic [ADDR_W-1:0] cycle,
    input  logic              seg_req,
    input  logic              we,
    input  logic              wseg,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  mod,
    output logic              mod_valid,
    output logic [ADDR_W-1:0] idx,
    output logic              seg_act,
    output logic              swap_done
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              w_step;
    logic              w_prime;
    logic              w_tick_run;
    logic              w_div_hit;
    logic              w_wrap;

    logic [DIV_W-1:0]  r_div_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_seg;
    logic              r_swap_evt;
    logic              r_swap_done;
    logic              r_rd_req;
    logic              r_rd_req_d;
    logic [WIDTH-1:0]  r_mod;
    logic              r_mod_valid;
    logic [WIDTH-1:0]  w_ram_q;

    // Compare against the divider as it stands now, so a shrink mid-count steps once.
    assign w_div_hit  = 32'(r_div_cnt) >= (eff_div(32'(freq_div)) - 32'd1);
    assign w_tick_run = (r_state == RUN_S) && run && sync_tick;
    assign w_wrap     = r_idx >= cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_prime     = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nxt = PRIME;
                    w_prime     = 1'b1;
                end
            end
            PRIME: begin
                w_state_nxt = RUN_S;
            end
            RUN_S: begin
                if (!run) begin
                    w_state_nxt = IDLE;
                end else if (sync_tick && w_div_hit) begin
                    w_step = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick_run) begin
            if (w_div_hit) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Segment request is only honoured on the wrap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_seg       <= 1'b0;
            r_swap_evt  <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_swap_evt  <= 1'b0;
            r_swap_done <= r_swap_evt;
            if (w_step) begin
                if (w_wrap) begin
                    r_idx <= '0;
                    if (seg_req != r_seg) begin
                        r_seg      <= seg_req;
                        r_swap_evt <= 1'b1;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Read request follows the step/prime edge; the RAM samples {seg,idx} one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_req    <= 1'b0;
            r_rd_req_d  <= 1'b0;
            r_mod       <= '0;
            r_mod_valid <= 1'b0;
        end else begin
            r_rd_req    <= w_step | w_prime;
            r_rd_req_d  <= r_rd_req;
            r_mod_valid <= r_rd_req_d;
            if (r_rd_req_d) begin
                r_mod <= w_ram_q;
            end
        end
    end

    mod_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (2 * DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr ({wseg, waddr}),
        .wdata (wdata),
        .re    (r_rd_req),
        .raddr ({r_seg, r_idx}),
        .rdata (w_ram_q)
    );

    assign mod       = r_mod;
    assign mod_valid = r_mod_valid;
    assign idx       = r_idx;
    assign seg_act   = r_seg;
    assign swap_done = r_swap_done;

endmodule
`default_nettype wire
